relu_stream_act: RTL and testbench
==================================

Name: relu_stream_act

Overview:
- Pipelined, multi-lane activation unit; generalised successor of the single-word combinational ReLU.
- Sits between the convolution accumulator output and the feature-map writeback buffer.
- Per beat it applies one of four modes to LANES signed words: ReLU, leaky ReLU, clipped ReLU or bypass.
- It then requantizes each word (round, arithmetic shift, saturate) and counts zeroed outputs for sparsity statistics.

Parameters:
- LANES, 4: words per beat.
- IN_W, 32: signed input word width; defaults to the internal accumulator width.
- OUT_W, 16: signed output word width; must satisfy 2 <= OUT_W <= IN_W.
- LEAK_SHIFT, 3: leaky-mode negative slope is 2^-LEAK_SHIFT.
- CNT_W, 32: width of the zero-output counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit accepts a beat this cycle.
- in_data  in  LANES*IN_W  packed signed words; lane 0 in the LSBs.
- in_mode  in  2  activation mode: 0 ReLU, 1 leaky, 2 clip, 3 bypass.
- in_clip  in  IN_W  clip ceiling for mode 2; treated as unsigned and non-negative.
- in_qshift  in  5  requantize right shift amount, 0..31.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*OUT_W  packed signed results.
- zero_cnt  out  CNT_W  lanes output as exactly zero since the last clear.
- cnt_clr  in  1  synchronous clear of zero_cnt.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both stage valid flags are cleared.
  - out_valid=0, out_data=0, zero_cnt=0.
  - Data registers are cleared.
  - in_ready is combinational and reads 1 once out of reset.
- Reset mid-operation discards any in-flight beats without emitting them.
- Pipeline: two register stages, latency exactly 2 cycles from an accepted beat to out_valid when out_ready is held high.
  - S1 registers the activation result: IN_W+1 bits per lane, plus in_qshift.
  - S2 registers the requantized OUT_W result.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A beat is emitted when out_valid && out_ready.
  - Stage k advances when it is empty or the next stage advances.
  - in_ready = !s1_valid || s1_advance. This is a full-throughput bubble-collapsing pipeline with one beat per cycle sustained.
  - While out_valid && !out_ready, out_data is held stable.
  - in_mode, in_clip and in_qshift are sampled with each accepted beat and travel with it. Mode changes between beats take effect with no flush.
- Activation, per lane, with x signed IN_W:
  - Mode 0: x <= 0 gives 0; otherwise x.
  - Mode 1: x < 0 gives x >>> LEAK_SHIFT (arithmetic, floor; e.g. -1 gives -1); otherwise x.
  - Mode 2: x <= 0 gives 0; x > in_clip gives in_clip; otherwise x.
  - Mode 3: x unchanged.
- Requantize, per lane, with a the activation result and s = in_qshift:
  - r = (a + (s > 0 ? 2^(s-1) : 0)) >>> s, computed at IN_W+1 bits so the rounding add never wraps. This is round-half-up toward +inf.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Zero counter:
  - On each emitted beat, zero_cnt adds the number of lanes whose out_data word equals 0.
  - The count saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr sets zero_cnt to 0 on the next edge.
  - If cnt_clr coincides with an emitted beat, clear wins and that beat is not counted.
- Simultaneous accept and emit in one cycle is legal. Occupancy is unchanged and no beat is dropped or duplicated.

Decomposition:
- Shared definitions header holds:
  - mode encodings MODE_RELU=0, MODE_LEAKY=1, MODE_CLIP=2, MODE_BYPASS=3;
  - default IN_W, matching the internal accumulator width.
- Sub-module act_lane: a combinational per-lane activation plus requantize/saturate function, instantiated LANES times via generate. Both of its halves are registered in the parent.
- The parent owns the handshake, pipeline registers and popcount/counter.

Test Plan:
- LANES=4, mode 0, out_ready=1, qshift=0, lanes {-5, 0, 7, 40000} -> two cycles later out_data {0, 0, 7, 32767}; zero_cnt += 2.
- Mode 1, LEAK_SHIFT=3, qshift=0, lanes {-1, -16, -17, 9} -> {-1, -2, -3, 9}.
- Mode 2, clip=100, qshift=2, lanes {-3, 50, 101, 6} -> {0, 13, 25, 2}, with 50+2=52>>2=13, 100+2=102>>2=25, 6+2=8>>2=2.
- Back-to-back 8 beats, out_ready low for cycles 3-5:
  - in_ready drops after both stages fill;
  - out_data stays stable while stalled;
  - all 8 beats emerge in order with no loss or duplication;
  - throughput returns to 1 beat/cycle after release.
- Two beats in flight, assert rst_n=0 asynchronously mid-cycle:
  - out_valid=0 and zero_cnt=0 immediately;
  - no stale beat appears after release.
- Counter boundaries, using CNT_W=4 override and mode 0 all-negative beats:
  - zero_cnt reaches 15 and holds;
  - cnt_clr asserted on the same cycle as an emitted all-zero beat gives zero_cnt=0 next cycle.

Source files
------------

// File: rtl/relu_stream_act_pkg.sv
// Shared definitions for the streaming activation unit: mode encodings and
// the default accumulator word width.
package relu_stream_act_pkg;

  localparam int DEF_IN_W = 32;

  typedef enum logic [1:0] {
    MODE_RELU   = 2'd0,
    MODE_LEAKY  = 2'd1,
    MODE_CLIP   = 2'd2,
    MODE_BYPASS = 2'd3
  } act_mode_e;

endpackage

// File: rtl/relu_stream_act_lane.sv
// One lane, purely combinational: activation (x -> IN_W+1 bit a) and
// requantize (round half up, arithmetic shift, saturate to OUT_W).
module relu_stream_act_lane
  import relu_stream_act_pkg::*;
#(
  parameter int IN_W       = DEF_IN_W,
  parameter int OUT_W      = 16,
  parameter int LEAK_SHIFT = 3
) (
  input  logic [IN_W-1:0]  i_x,
  input  logic [1:0]       i_mode,
  input  logic [IN_W-1:0]  i_clip,
  output logic [IN_W:0]    o_act,
  input  logic [IN_W:0]    i_act,
  input  logic [4:0]       i_qshift,
  output logic [OUT_W-1:0] o_q
);

  localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] SAT_MIN = ~SAT_MAX;

  logic signed [IN_W-1:0] w_x;
  logic signed [IN_W-1:0] w_leak;
  logic                   w_nonpos;
  logic signed [IN_W:0]   w_a;
  logic signed [IN_W:0]   w_rnd;
  logic signed [IN_W:0]   w_sum;
  logic signed [IN_W:0]   w_shr;

  assign w_x      = i_x;
  assign w_leak   = w_x >>> LEAK_SHIFT;
  assign w_nonpos = w_x[IN_W-1] || (w_x == '0);

  always_comb begin
    o_act = {w_x[IN_W-1], w_x};
    case (act_mode_e'(i_mode))
      MODE_RELU: begin
        if (w_nonpos) o_act = '0;
      end
      MODE_LEAKY: begin
        if (w_x[IN_W-1]) o_act = {w_leak[IN_W-1], w_leak};
      end
      MODE_CLIP: begin
        // x is known positive here, so an unsigned compare against the ceiling is exact
        if (w_nonpos)          o_act = '0;
        else if (i_x > i_clip) o_act = {1'b0, i_clip};
      end
      MODE_BYPASS: begin
      end
    endcase
  end

  assign w_a   = i_act;
  assign w_rnd = ({{IN_W{1'b0}}, 1'b1} << i_qshift) >> 1;
  assign w_sum = w_a + w_rnd;
  assign w_shr = w_sum >>> i_qshift;

  always_comb begin
    o_q = w_shr[OUT_W-1:0];
    if (w_shr > SAT_MAX)      o_q = SAT_MAX[OUT_W-1:0];
    else if (w_shr < SAT_MIN) o_q = SAT_MIN[OUT_W-1:0];
  end

endmodule

// File: rtl/relu_stream_act.sv
// Multi-lane activation + requantize stream, 2-cycle latency, full throughput.
// Valid/ready backpressure collapses bubbles; output held stable while stalled.
module relu_stream_act
  import relu_stream_act_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int IN_W       = DEF_IN_W,
  parameter int OUT_W      = 16,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  input  logic [1:0]             in_mode,
  input  logic [IN_W-1:0]        in_clip,
  input  logic [4:0]             in_qshift,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [CNT_W-1:0]       zero_cnt,
  input  logic                   cnt_clr
);

  localparam int ZL_W = $clog2(LANES + 1);

  logic                   r_s1_vld;
  logic [IN_W:0]          r_s1_act [LANES];
  logic [4:0]             r_s1_qshift;
  logic                   r_s2_vld;
  logic [LANES*OUT_W-1:0] r_s2_dat;
  logic [CNT_W-1:0]       r_zero_cnt;

  logic [IN_W:0]          w_act [LANES];
  logic [LANES*OUT_W-1:0] w_q;
  logic                   w_s1_adv;
  logic                   w_s2_adv;
  logic                   w_emit;
  logic [ZL_W-1:0]        w_zero_lanes;
  logic [CNT_W:0]         w_cnt_sum;

  assign w_s2_adv  = !r_s2_vld || out_ready;
  assign w_s1_adv  = !r_s1_vld || w_s2_adv;
  assign w_emit    = r_s2_vld && out_ready;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_vld;
  assign out_data  = r_s2_dat;
  assign zero_cnt  = r_zero_cnt;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    relu_stream_act_lane #(
      .IN_W      (IN_W),
      .OUT_W     (OUT_W),
      .LEAK_SHIFT(LEAK_SHIFT)
    ) u_lane (
      .i_x     (in_data[l*IN_W +: IN_W]),
      .i_mode  (in_mode),
      .i_clip  (in_clip),
      .o_act   (w_act[l]),
      .i_act   (r_s1_act[l]),
      .i_qshift(r_s1_qshift),
      .o_q     (w_q[l*OUT_W +: OUT_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld    <= 1'b0;
      r_s1_qshift <= '0;
      for (int l = 0; l < LANES; l++) r_s1_act[l] <= '0;
    end else if (w_s1_adv) begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_qshift <= in_qshift;
        for (int l = 0; l < LANES; l++) r_s1_act[l] <= w_act[l];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld <= 1'b0;
      r_s2_dat <= '0;
    end else if (w_s2_adv) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) r_s2_dat <= w_q;
    end
  end

  always_comb begin
    w_zero_lanes = '0;
    for (int l = 0; l < LANES; l++) begin
      if (r_s2_dat[l*OUT_W +: OUT_W] == '0) w_zero_lanes = w_zero_lanes + ZL_W'(1);
    end
  end

  // One extra bit catches the carry so the count pins at all-ones instead of wrapping
  assign w_cnt_sum = {1'b0, r_zero_cnt} + (CNT_W+1)'(w_zero_lanes);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero_cnt <= '0;
    end else if (cnt_clr) begin
      r_zero_cnt <= '0;
    end else if (w_emit) begin
      r_zero_cnt <= w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_relu_stream_act.sv
// Bench for relu_stream_act: directed mode vectors, stall/backpressure, random
// traffic against an arithmetic reference model, async reset and counter limits.
module tb_relu_stream_act;

  localparam int LANES = 4;
  localparam int IN_W  = 32;
  localparam int OUT_W = 16;
  localparam int LEAK  = 3;
  localparam int BW    = LANES * OUT_W;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready, in_ready4;
  logic [LANES*IN_W-1:0] in_data = '0;
  logic [1:0]            in_mode = '0;
  logic [IN_W-1:0]       in_clip = '0;
  logic [4:0]            in_qshift = '0;
  logic                  out_valid, out_valid4;
  logic                  out_ready = 1'b1;
  logic [BW-1:0]         out_data, out_data4;
  logic [31:0]           zero_cnt;
  logic [3:0]            zero_cnt4;
  logic                  cnt_clr = 1'b0;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_zero = '0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] got_q[$];

  always #5 clk = ~clk;

  relu_stream_act u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .in_clip(in_clip), .in_qshift(in_qshift),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .zero_cnt(zero_cnt), .cnt_clr(cnt_clr)
  );

  relu_stream_act #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_mode(in_mode), .in_clip(in_clip), .in_qshift(in_qshift),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .zero_cnt(zero_cnt4), .cnt_clr(cnt_clr)
  );

  function automatic logic [BW-1:0] model_beat(input logic [LANES*IN_W-1:0] d,
                                               input logic [1:0] m,
                                               input logic [IN_W-1:0] clip,
                                               input logic [4:0] s);
    logic [BW-1:0] res;
    longint x, a, r, c;
    res = '0;
    c = {32'b0, clip};
    for (int l = 0; l < LANES; l++) begin
      x = $signed(d[l*IN_W +: IN_W]);
      case (m)
        2'd0:    a = (x <= 0) ? 0 : x;
        2'd1:    a = (x < 0) ? (x >>> LEAK) : x;
        2'd2:    a = (x <= 0) ? 0 : ((x > c) ? c : x);
        default: a = x;
      endcase
      r = (a + ((s > 0) ? (64'sd1 <<< (s - 1)) : 64'sd0)) >>> s;
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      res[l*OUT_W +: OUT_W] = r[15:0];
    end
    return res;
  endfunction

  function automatic int zero_lanes(input logic [BW-1:0] b);
    int n = 0;
    for (int l = 0; l < LANES; l++) if (b[l*OUT_W +: OUT_W] == '0) n++;
    return n;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 400)) - 32'd200;
      2:       return '0;
      default: return 32'($urandom_range(0, 1 << 20)) - 32'd524288;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) exp_q.push_back(model_beat(in_data, in_mode, in_clip, in_qshift));
    if (rst_n && out_valid && out_ready) got_q.push_back(out_data);
  end

  task automatic send_one(input logic [LANES*IN_W-1:0] d, input logic [1:0] m,
                          input logic [IN_W-1:0] c, input logic [4:0] s);
    in_valid = 1'b1; in_data = d; in_mode = m; in_clip = c; in_qshift = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got %0h want 0", out_data); end
    total++; if (zero_cnt !== '0) begin bad++; $display("FAIL reset_zero_cnt got %0d want 0", zero_cnt); end
    total++; if (zero_cnt4 !== '0) begin bad++; $display("FAIL reset_zero_cnt4 got %0d want 0", zero_cnt4); end
    @(negedge clk); rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %0h want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_modes();
    logic [LANES*IN_W-1:0] din [3];
    logic [BW-1:0]         dexp [3];
    logic [1:0]            mode [3];
    logic [IN_W-1:0]       clip [3];
    logic [4:0]            qs [3];
    int                    nz [3];
    din[0] = {32'd40000, 32'd7, 32'd0, 32'hFFFF_FFFB};
    dexp[0] = {16'h7FFF, 16'h0007, 16'h0000, 16'h0000};
    mode[0] = 2'd0; clip[0] = 32'd0; qs[0] = 5'd0; nz[0] = 2;
    din[1] = {32'd9, 32'hFFFF_FFEF, 32'hFFFF_FFF0, 32'hFFFF_FFFF};
    dexp[1] = {16'h0009, 16'hFFFD, 16'hFFFE, 16'hFFFF};
    mode[1] = 2'd1; clip[1] = 32'd0; qs[1] = 5'd0; nz[1] = 0;
    din[2] = {32'd6, 32'd101, 32'd50, 32'hFFFF_FFFD};
    dexp[2] = {16'h0002, 16'h0019, 16'h000D, 16'h0000};
    mode[2] = 2'd2; clip[2] = 32'd100; qs[2] = 5'd2; nz[2] = 1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_one(din[k], mode[k], clip[k], qs[k]);
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mode%0d_early_valid got %0h want 0", k, out_valid); end
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mode%0d_latency got %0h want 1", k, out_valid); end
      total++; if (out_data !== dexp[k]) begin bad++; $display("FAIL mode%0d_data got %0h want %0h", k, out_data, dexp[k]); end
      @(negedge clk);
      exp_zero = exp_zero + 32'(nz[k]);
      total++; if (zero_cnt !== exp_zero) begin bad++; $display("FAIL mode%0d_zero_cnt got %0d want %0d", k, zero_cnt, exp_zero); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [LANES*IN_W-1:0] bd [8];
    logic [1:0]            bm [8];
    logic [IN_W-1:0]       bc [8];
    logic [4:0]            bs [8];
    int                    idx = 0;
    logic                  acc;
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 8; i++) begin
      bd[i] = {rand_word(), rand_word(), rand_word(), rand_word()};
      bm[i] = 2'($urandom_range(0, 3));
      bc[i] = 32'($urandom_range(0, 5000));
      bs[i] = 5'($urandom_range(0, 6));
    end
    for (int c = 0; c < 40 && got_q.size() < 8; c++) begin
      in_valid = (idx < 8);
      if (idx < 8) begin in_data = bd[idx]; in_mode = bm[idx]; in_clip = bc[idx]; in_qshift = bs[idx]; end
      out_ready = !(c >= 3 && c <= 5);
      @(negedge clk);
      if (c == 3) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_in_ready_full got %0h want 0", in_ready); end
      end
      if (c >= 3 && c <= 5) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_stall_valid c=%0d got %0h want 1", c, out_valid); end
        total++; if (exp_q.size() < 2 || out_data !== exp_q[1]) begin
          bad++; $display("FAIL b2b_stall_hold c=%0d got %0h want beat1", c, out_data);
        end
      end
      if (c >= 6 && c <= 12) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_throughput c=%0d got %0h want 1", c, out_valid); end
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (got_q.size() != 8 || exp_q.size() != 8) begin
      bad++; $display("FAIL b2b_count got %0d want 8 (accepted %0d)", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < 8 && i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_beat%0d got %0h want %0h", i, got_q[i], exp_q[i]); end
      exp_zero = exp_zero + 32'(zero_lanes(exp_q[i]));
    end
    total++; if (zero_cnt !== exp_zero) begin bad++; $display("FAIL b2b_zero_cnt got %0d want %0d", zero_cnt, exp_zero); end
  endtask

  task automatic test_random();
    int   n_sent = 0;
    logic acc;
    exp_q.delete(); got_q.delete();
    for (int c = 0; c < 3000 && got_q.size() < 200; c++) begin
      if (!in_valid && n_sent < 200 && $urandom_range(0, 9) < 7) begin
        in_valid  = 1'b1;
        in_data   = {rand_word(), rand_word(), rand_word(), rand_word()};
        in_mode   = 2'($urandom_range(0, 3));
        in_clip   = 32'($urandom_range(0, 3000));
        in_qshift = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 4)) : 5'($urandom_range(0, 31));
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin n_sent++; in_valid = 1'b0; end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (got_q.size() != 200 || exp_q.size() != 200) begin
      bad++; $display("FAIL rand_count got %0d want 200 (accepted %0d)", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_beat%0d got %0h want %0h", i, got_q[i], exp_q[i]); end
      exp_zero = exp_zero + 32'(zero_lanes(exp_q[i]));
    end
    total++; if (zero_cnt !== exp_zero) begin bad++; $display("FAIL rand_zero_cnt got %0d want %0d", zero_cnt, exp_zero); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'd3; in_qshift = 5'd0;
    in_data = {32'd11, 32'd22, 32'd33, 32'd44};
    @(posedge clk); #1;
    in_data = {32'd55, 32'd66, 32'd77, 32'd88};
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_precond got %0h want 1", out_valid); end
    #2; rst_n = 1'b0; #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got %0h want 0", out_valid); end
    total++; if (zero_cnt !== '0) begin bad++; $display("FAIL midrst_zero_cnt got %0d want 0", zero_cnt); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL midrst_out_data got %0h want 0", out_data); end
    exp_zero = '0;
    @(posedge clk); #3;
    rst_n = 1'b1; out_ready = 1'b1;
    got_q.delete(); exp_q.delete();
    repeat (6) @(posedge clk);
    #1;
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL midrst_stale got %0d beats want 0", got_q.size()); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got %0h want 1", in_ready); end
  endtask

  task automatic test_counter();
    int e;
    logic [LANES*IN_W-1:0] neg;
    neg = {32'hFFFF_FF00, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_0001};
    out_ready = 1'b1;
    cnt_clr = 1'b1; @(posedge clk); #1; cnt_clr = 1'b0;
    exp_zero = '0;
    total++; if (zero_cnt4 !== 4'd0) begin bad++; $display("FAIL cnt_clr_idle got %0d want 0", zero_cnt4); end
    for (int b = 0; b < 5; b++) begin
      send_one(neg, 2'd0, 32'd0, 5'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      e = 4 * (b + 1);
      if (e > 15) e = 15;
      exp_zero = exp_zero + 32'd4;
      total++; if (zero_cnt4 !== 4'(e)) begin bad++; $display("FAIL cnt_sat_b%0d got %0d want %0d", b, zero_cnt4, e); end
    end
    total++; if (zero_cnt !== exp_zero) begin bad++; $display("FAIL cnt_wide got %0d want %0d", zero_cnt, exp_zero); end
    send_one(neg, 2'd0, 32'd0, 5'd0);
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    total++; if (out_valid4 !== 1'b1) begin bad++; $display("FAIL cnt_clr_emit_valid got %0h want 1", out_valid4); end
    total++; if (out_data4 !== '0) begin bad++; $display("FAIL cnt_clr_emit_data got %0h want 0", out_data4); end
    total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL cnt_clr_in_ready got %0h want 1", in_ready4); end
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    exp_zero = '0;
    total++; if (zero_cnt4 !== 4'd0) begin bad++; $display("FAIL cnt_clr_wins got %0d want 0", zero_cnt4); end
    total++; if (zero_cnt !== exp_zero) begin bad++; $display("FAIL cnt_clr_wins_wide got %0d want 0", zero_cnt); end
    @(posedge clk); #1;
    total++; if (zero_cnt4 !== 4'd0) begin bad++; $display("FAIL cnt_clr_after got %0d want 0", zero_cnt4); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_modes();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    test_counter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
